// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and parity helper for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {WL5, WL6, WL7, WL8} word_len_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // Stick parity forces the bit to ~even regardless of the data.
    function automatic logic uart_parity(input logic [7:0] data, input word_len_e word_len,
                                         input logic even, input logic stick);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - word_len);
        if (stick) begin
            return ~even;
        end
        return (^(data & mask)) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - byte-to-UART-frame serialiser paced by the baud divisor tick
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] cfg_word_len,
    input  logic       cfg_stop2,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_even,
    input  logic       cfg_parity_stick,
    input  logic       cfg_break,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(2 * OVERSAMPLE);
    localparam logic [CW-1:0] BIT_LIM    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP15_LIM = CW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] STOP2_LIM  = CW'(2 * OVERSAMPLE - 1);

    tx_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    last, last_n;
    logic [CW-1:0] stop_lim, stop_lim_n;
    logic          par_en, par_en_n;
    logic          par_bit, par_bit_n;
    logic          line, line_n;
    logic          done_n;
    logic [CW-1:0] lim;
    logic          bit_end;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        sh_n       = sh;
        last_n     = last;
        stop_lim_n = stop_lim;
        par_en_n   = par_en;
        par_bit_n  = par_bit;
        line_n     = line;
        done_n     = 1'b0;
        lim        = (state == STOP) ? stop_lim : BIT_LIM;
        bit_end    = tick && (cnt == lim);

        if (state != IDLE && tick) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                line_n = 1'b1;
                if (in_valid) begin
                    // Whole frame shape is captured here so mid-frame cfg edits are harmless.
                    state_n    = START;
                    line_n     = 1'b0;
                    sh_n       = in_data;
                    last_n     = 3'(cfg_word_len) + 3'd4;
                    par_en_n   = cfg_parity_en;
                    par_bit_n  = uart_parity(in_data, word_len_e'(cfg_word_len),
                                             cfg_parity_even, cfg_parity_stick);
                    stop_lim_n = !cfg_stop2           ? BIT_LIM :
                                 (cfg_word_len == 2'd0) ? STOP15_LIM : STOP2_LIM;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    line_n  = sh[0];
                    sh_n    = sh >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == last) begin
                        state_n = par_en ? PARITY : STOP;
                        line_n  = par_en ? par_bit : 1'b1;
                    end else begin
                        idx_n  = idx + 3'd1;
                        line_n = sh[0];
                        sh_n   = sh >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    line_n  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    line_n  = 1'b1;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            last       <= '0;
            stop_lim   <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            line       <= 1'b1;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            last       <= last_n;
            stop_lim   <= stop_lim_n;
            par_en     <= par_en_n;
            par_bit    <= par_bit_n;
            line       <= line_n;
            // Break overrides the line level but leaves frame timing untouched.
            tx         <= line_n & ~cfg_break;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - randomized self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n, tick, in_valid, in_ready;
    logic [7:0] in_data;
    logic [1:0] cfg_word_len;
    logic       cfg_stop2, cfg_parity_en, cfg_parity_even, cfg_parity_stick, cfg_break;
    logic       tx, busy, frame_done;

    int errors = 0;
    int checks = 0;

    uart_tx_framer #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_word_len(cfg_word_len), .cfg_stop2(cfg_stop2),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_even(cfg_parity_even),
        .cfg_parity_stick(cfg_parity_stick), .cfg_break(cfg_break),
        .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame from an idle DUT and checks every cycle of it against a
    // list of (level, tick-length) pieces built from the framing rules.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                             input logic pe, input logic ev, input logic st,
                             input int period, input int brk_start, input logic hold,
                             input string name, output int cycles);
        int bits[12];
        int lens[12];
        int nb, n, ones, total, ticks, c, k, cum, tx_bad, ctl_bad, first_bad;
        logic exp_tx, tk, brk, done;

        n = 5 + int'(wl);
        ones = 0;
        bits[0] = 0; lens[0] = OS;
        for (int i = 0; i < n; i++) begin
            bits[1 + i] = int'(d[i]);
            lens[1 + i] = OS;
            ones += int'(d[i]);
        end
        nb = 1 + n;
        if (pe) begin
            if (st) bits[nb] = ev ? 0 : 1;
            else    bits[nb] = ev ? (ones % 2) : 1 - (ones % 2);
            lens[nb] = OS;
            nb++;
        end
        bits[nb] = 1;
        lens[nb] = !s2 ? OS : (n == 5 ? (3 * OS) / 2 : 2 * OS);
        nb++;
        total = 0;
        for (int i = 0; i < nb; i++) total += lens[i];

        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_start: got %b want 1", name, in_ready);
        end

        in_valid = 1'b1; in_data = d;
        cfg_word_len = wl; cfg_stop2 = s2; cfg_parity_en = pe;
        cfg_parity_even = ev; cfg_parity_stick = st;
        cfg_break = (brk_start == 0);
        tick = 1'b1;
        @(posedge clk);
        brk = cfg_break;
        #1;
        in_valid = hold;
        in_data = 8'($urandom);
        cfg_word_len = 2'($urandom); cfg_stop2 = 1'($urandom); cfg_parity_en = 1'($urandom);
        cfg_parity_even = 1'($urandom); cfg_parity_stick = 1'($urandom);

        ticks = 0; c = 0; done = 1'b0; tx_bad = 0; ctl_bad = 0; first_bad = -1;
        while (!done && c <= total * period + 8) begin
            if (ticks == total) begin
                done = 1'b1;
                exp_tx = ~brk;
                if (frame_done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) ctl_bad++;
            end else begin
                k = 0; cum = lens[0];
                while (ticks >= cum) begin
                    k++;
                    cum += lens[k];
                end
                exp_tx = brk ? 1'b0 : 1'(bits[k]);
                if (frame_done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) ctl_bad++;
            end
            if (tx !== exp_tx) begin
                tx_bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (!done) begin
                c++;
                tick = ((c % period) == 0);
                cfg_break = (brk_start >= 0 && c >= brk_start);
                @(posedge clk);
                tk = tick; brk = cfg_break;
                #1;
                if (tk) ticks++;
            end
        end
        cycles = c;
        tick = 1'b0;
        cfg_break = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s frame_timeout: ticks %0d of %0d after %0d cycles", name, ticks, total, c);
        end
        checks++;
        if (tx_bad !== 0) begin
            errors++;
            $display("FAIL %s tx_waveform: %0d bad cycles, first at cycle %0d, want 0", name, tx_bad, first_bad);
        end
        checks++;
        if (ctl_bad !== 0) begin
            errors++;
            $display("FAIL %s busy_ready_done: %0d bad cycles, want 0", name, ctl_bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        cfg_word_len = 2'd3; cfg_stop2 = 1'b0; cfg_parity_en = 1'b0;
        cfg_parity_even = 1'b0; cfg_parity_stick = 1'b0; cfg_break = 1'b1;
        step(); step();
        checks++;
        if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_state: tx/busy/ready/done=%b want 1010", {tx, busy, in_ready, frame_done});
        end
        rst_n = 1'b1; in_valid = 1'b0; tick = 1'b0; cfg_break = 1'b0;
        step();
    endtask

    task automatic test_8n1();
        int cyc;
        run_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, "8n1_a5", cyc);
        checks++;
        if (cyc !== 160) begin
            errors++;
            $display("FAIL 8n1_frame_len: got %0d cycles want 160", cyc);
        end
        step();
    endtask

    task automatic test_parity();
        int cyc;
        run_frame(8'h03, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1, -1, 1'b0, "7e1_03", cyc);
        run_frame(8'h03, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0, "7o1_03", cyc);
        run_frame(8'h03, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1, -1, 1'b0, "7stick_03", cyc);
        run_frame(8'hFE, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2, -1, 1'b0, "8stick_odd", cyc);
    endtask

    task automatic test_stop_bits();
        int cyc;
        run_frame(8'hE6, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, "5n2", cyc);
        checks++;
        if (cyc !== 120) begin
            errors++;
            $display("FAIL 5n2_frame_len: got %0d cycles want 120", cyc);
        end
        run_frame(8'hD9, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, "6n2", cyc);
        checks++;
        if (cyc !== 144) begin
            errors++;
            $display("FAIL 6n2_frame_len: got %0d cycles want 144", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3, -1, 1'b1, "b2b_00", cyc);
        run_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3, -1, 1'b0, "b2b_ff", cyc);
        step();
    endtask

    task automatic test_break();
        int cyc;
        run_frame(8'h5A, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1, 40, 1'b0, "break", cyc);
        checks++;
        if (cyc !== 176) begin
            errors++;
            $display("FAIL break_frame_len: got %0d cycles want 176", cyc);
        end
        step(); step();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL break_release: tx=%b want 1", tx);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        in_valid = 1'b1; in_data = 8'h00; tick = 1'b1;
        cfg_word_len = 2'd3; cfg_stop2 = 1'b0; cfg_parity_en = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_mid_frame: tx/busy/ready/done=%b want 1010", {tx, busy, in_ready, frame_done});
        end
        rst_n = 1'b1; tick = 1'b0;
        step();
        run_frame(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, "after_reset", cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 8; i++) begin
            run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), int'($urandom_range(1, 3)), -1, 1'($urandom), "random", cyc);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_bits();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
